mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between the instruction-fetch requester and the load/store requester of the core.
- Latches single-cycle request pulses, grants one transaction at a time, and forwards the request to the downstream port.
- Routes the downstream response pulse back to the requester that owns the transaction.
- Sits between the core's fetch/mem request interfaces and the single cache/memory controller.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
STRB_W, DATA_W/8, byte-strobe width

Ports:
clk  input  1  system clock; the only clock
rstn  input  1  asynchronous active-low reset
fetch_req_en  input  1  one-cycle fetch request pulse
fetch_req_addr  input  ADDR_W  fetch address, valid with fetch_req_en
fetch_resp_en  output  1  one-cycle fetch response pulse
fetch_resp_data  output  DATA_W  fetched word, valid with fetch_resp_en
mem_req_en  input  1  one-cycle load/store request pulse
mem_req_we  input  1  1 = store, 0 = load
mem_req_addr  input  ADDR_W  load/store address
mem_req_wdata  input  DATA_W  store data
mem_req_wstrb  input  STRB_W  store byte enables
mem_resp_en  output  1  one-cycle load/store response pulse
mem_resp_data  output  DATA_W  load data; don't-care for stores
bus_req_en  output  1  one-cycle downstream request pulse
bus_req_we  output  1  downstream write flag
bus_req_addr  output  ADDR_W  downstream address
bus_req_wdata  output  DATA_W  downstream write data
bus_req_wstrb  output  STRB_W  downstream strobes; all zeros for fetches
bus_resp_en  input  1  one-cycle downstream response pulse
bus_resp_data  input  DATA_W  downstream read data
busy  output  1  1 while a transaction is outstanding

Behaviour:
- Clocking and reset: one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Both pending slots empty.
  - last_grant = fetch.
- Pending slots (one per requester):
  - A request pulse captures its fields into that requester's slot and sets the slot valid.
  - The capture happens in any state.
  - The slot stays valid until the requester's response pulse is issued.
- Protocol: each requester has at most one request outstanding.
  - A request pulse while that requester's slot is already valid is ignored.
  - The slot contents are unchanged.
  - No extra bus transaction results.
- State IDLE:
  - If either slot is valid, or a request pulse arrives this cycle, select a winner.
  - Next cycle: bus_req_en=1 for exactly one cycle, with the registered winner fields; owner recorded; state WAIT; busy=1.
  - Latency: request pulse at cycle t gives bus_req_en at t+1 when the arbiter was idle.
- State WAIT:
  - On bus_resp_en, next cycle the owner's resp_en=1 for one cycle, with resp_data = the captured bus_resp_data.
  - The other requester's resp_en stays 0.
  - The owner's slot is cleared and the state returns to IDLE.
  - Latency: bus_resp_en at u gives the owner's resp_en at u+1.
  - The earliest next bus_req_en is u+2.
- busy: asserted from the bus_req_en cycle through the cycle of the owner's resp_en.
- bus_req fields: held stable from the bus_req_en cycle until the transaction completes.
- Fetch requests: drive bus_req_we=0 and bus_req_wstrb=0.
- Ignored events:
  - bus_resp_en in IDLE is ignored.
  - A second bus_resp_en in the same WAIT is impossible, because the state leaves WAIT.
- Simultaneous events:
  - A response in WAIT and a new request in the same cycle: the request is captured into its slot and arbitrated in the following IDLE cycle.
  - A requester may pulse req_en in the same cycle its resp_en is high. The slot clears and re-captures that cycle, and the new request is accepted.
- Reset mid-transaction:
  - Everything returns to reset values.
  - A bus_resp_en arriving after reset release lands in IDLE and is dropped.
- Arbitration, default: fixed priority, mem over fetch.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined: round-robin arbitration.
  - When both slots are valid in IDLE, grant the requester opposite last_grant.
  - last_grant updates on every grant.
  - A single valid slot is granted immediately regardless of last_grant.
- Undefined: fixed priority, mem over fetch. The last_grant register is not built.
- All latencies are identical in both builds.

Test Plan:
1. Single fetch:
   - Stimulus: fetch_req_en at t with addr 0x0000_1000; bus_resp_en at t+4 with data 0xDEAD_BEEF.
   - Required: bus_req_en at t+1, addr 0x1000, we=0, wstrb=0; fetch_resp_en at t+5 with 0xDEAD_BEEF; mem_resp_en stays 0; busy high t+1..t+5.
2. Store:
   - Stimulus: mem_req_en, we=1, addr 0x2004, wdata 0x1234_5678, wstrb 0xF.
   - Required: bus fields match exactly; mem_resp_en exactly one cycle after bus_resp_en.
3. Simultaneous requests, fixed priority:
   - Stimulus: fetch 0x100 and load 0x200 pulsed in the same cycle.
   - Required: bus addr 0x200 first; 0x100 issued at the second cycle after the first bus_resp_en; each response goes to its own requester.
4. Round-robin with MEM_PORT_ARB_RR_EN:
   - Stimulus: both requesters re-request on every response, for 4 transactions.
   - Required: grants alternate mem, fetch, mem, fetch after reset, with last_grant = fetch at reset.
5. Protocol and stray responses:
   - Stimulus: a second fetch_req_en (addr 0x300) while fetch 0x100 is outstanding; a stray bus_resp_en while IDLE.
   - Required: only one bus request, with addr 0x100; no response pulse from the stray.
6. Reset mid-transaction:
   - Stimulus: assert rstn=0 while in WAIT; release; then bus_resp_en.
   - Required: all outputs 0 immediately on reset assertion; after release no resp_en fires; a new fetch is then served normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between the fetch and load/store requesters.
// Default build uses fixed mem-over-fetch priority; define MEM_PORT_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fetch_req_en,
    input  logic [ADDR_W-1:0] fetch_req_addr,
    output logic              fetch_resp_en,
    output logic [DATA_W-1:0] fetch_resp_data,
    input  logic              mem_req_en,
    input  logic              mem_req_we,
    input  logic [ADDR_W-1:0] mem_req_addr,
    input  logic [DATA_W-1:0] mem_req_wdata,
    input  logic [STRB_W-1:0] mem_req_wstrb,
    output logic              mem_resp_en,
    output logic [DATA_W-1:0] mem_resp_data,
    output logic              bus_req_en,
    output logic              bus_req_we,
    output logic [ADDR_W-1:0] bus_req_addr,
    output logic [DATA_W-1:0] bus_req_wdata,
    output logic [STRB_W-1:0] bus_req_wstrb,
    input  logic              bus_resp_en,
    input  logic [DATA_W-1:0] bus_resp_data,
    output logic              busy
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_MEM   = 1'b1;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   busy_q,  busy_d;

    logic              fetch_vld_q,  fetch_vld_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;

    logic              mem_vld_q,   mem_vld_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;

    logic              bus_req_en_q,    bus_req_en_d;
    logic              bus_req_we_q,    bus_req_we_d;
    logic [ADDR_W-1:0] bus_req_addr_q,  bus_req_addr_d;
    logic [DATA_W-1:0] bus_req_wdata_q, bus_req_wdata_d;
    logic [STRB_W-1:0] bus_req_wstrb_q, bus_req_wstrb_d;

    logic              fetch_resp_en_q,   fetch_resp_en_d;
    logic [DATA_W-1:0] fetch_resp_data_q, fetch_resp_data_d;
    logic              mem_resp_en_q,     mem_resp_en_d;
    logic [DATA_W-1:0] mem_resp_data_q,   mem_resp_data_d;

    logic              fetch_pend, mem_pend;
    logic              grant_mem, grant_fire, resp_fire;
    logic [ADDR_W-1:0] fetch_addr_eff, mem_addr_eff;
    logic              mem_we_eff;
    logic [DATA_W-1:0] mem_wdata_eff;
    logic [STRB_W-1:0] mem_wstrb_eff;

    // A pending request is either a held slot or a fresh pulse into an empty slot.
    assign fetch_pend     = fetch_vld_q | fetch_req_en;
    assign mem_pend       = mem_vld_q | mem_req_en;
    assign fetch_addr_eff = fetch_vld_q ? fetch_addr_q : fetch_req_addr;
    assign mem_we_eff     = mem_vld_q ? mem_we_q    : mem_req_we;
    assign mem_addr_eff   = mem_vld_q ? mem_addr_q  : mem_req_addr;
    assign mem_wdata_eff  = mem_vld_q ? mem_wdata_q : mem_req_wdata;
    assign mem_wstrb_eff  = mem_vld_q ? mem_wstrb_q : mem_req_wstrb;

    assign resp_fire  = (state_q == ST_WAIT) & bus_resp_en;
    assign grant_fire = (state_q == ST_IDLE) & (fetch_pend | mem_pend);

`ifdef MEM_PORT_ARB_RR_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_fire) begin
            last_grant_d = grant_mem;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant_q <= OWN_FETCH;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // On contention, hand the port to whoever did not get it last time.
    always_comb begin
        grant_mem = mem_pend;
        if (mem_pend && fetch_pend) begin
            grant_mem = (last_grant_q == OWN_FETCH);
        end
    end
`else
    assign grant_mem = mem_pend;
`endif

    // Pending slots: clear on the owner's response, capture a pulse only into an empty slot.
    always_comb begin
        fetch_vld_d  = fetch_vld_q;
        fetch_addr_d = fetch_addr_q;
        mem_vld_d    = mem_vld_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        if (resp_fire && (owner_q == OWN_FETCH)) begin
            fetch_vld_d = 1'b0;
        end
        if (resp_fire && (owner_q == OWN_MEM)) begin
            mem_vld_d = 1'b0;
        end
        if (fetch_req_en && !fetch_vld_q) begin
            fetch_vld_d  = 1'b1;
            fetch_addr_d = fetch_req_addr;
        end
        if (mem_req_en && !mem_vld_q) begin
            mem_vld_d   = 1'b1;
            mem_we_d    = mem_req_we;
            mem_addr_d  = mem_req_addr;
            mem_wdata_d = mem_req_wdata;
            mem_wstrb_d = mem_req_wstrb;
        end
    end

    // Transaction FSM: issue one bus request from IDLE, route the response back from WAIT.
    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        busy_d            = busy_q;
        bus_req_en_d      = 1'b0;
        bus_req_we_d      = bus_req_we_q;
        bus_req_addr_d    = bus_req_addr_q;
        bus_req_wdata_d   = bus_req_wdata_q;
        bus_req_wstrb_d   = bus_req_wstrb_q;
        fetch_resp_en_d   = 1'b0;
        fetch_resp_data_d = fetch_resp_data_q;
        mem_resp_en_d     = 1'b0;
        mem_resp_data_d   = mem_resp_data_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (grant_fire) begin
                    state_d      = ST_WAIT;
                    busy_d       = 1'b1;
                    bus_req_en_d = 1'b1;
                    owner_d      = grant_mem;
                    if (grant_mem) begin
                        bus_req_we_d    = mem_we_eff;
                        bus_req_addr_d  = mem_addr_eff;
                        bus_req_wdata_d = mem_wdata_eff;
                        bus_req_wstrb_d = mem_wstrb_eff;
                    end else begin
                        bus_req_we_d    = 1'b0;
                        bus_req_addr_d  = fetch_addr_eff;
                        bus_req_wdata_d = '0;
                        bus_req_wstrb_d = '0;
                    end
                end
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                if (bus_resp_en) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_MEM) begin
                        mem_resp_en_d   = 1'b1;
                        mem_resp_data_d = bus_resp_data;
                    end else begin
                        fetch_resp_en_d   = 1'b1;
                        fetch_resp_data_d = bus_resp_data;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q           <= ST_IDLE;
            owner_q           <= OWN_FETCH;
            busy_q            <= 1'b0;
            fetch_vld_q       <= 1'b0;
            fetch_addr_q      <= '0;
            mem_vld_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            mem_addr_q        <= '0;
            mem_wdata_q       <= '0;
            mem_wstrb_q       <= '0;
            bus_req_en_q      <= 1'b0;
            bus_req_we_q      <= 1'b0;
            bus_req_addr_q    <= '0;
            bus_req_wdata_q   <= '0;
            bus_req_wstrb_q   <= '0;
            fetch_resp_en_q   <= 1'b0;
            fetch_resp_data_q <= '0;
            mem_resp_en_q     <= 1'b0;
            mem_resp_data_q   <= '0;
        end else begin
            state_q           <= state_d;
            owner_q           <= owner_d;
            busy_q            <= busy_d;
            fetch_vld_q       <= fetch_vld_d;
            fetch_addr_q      <= fetch_addr_d;
            mem_vld_q         <= mem_vld_d;
            mem_we_q          <= mem_we_d;
            mem_addr_q        <= mem_addr_d;
            mem_wdata_q       <= mem_wdata_d;
            mem_wstrb_q       <= mem_wstrb_d;
            bus_req_en_q      <= bus_req_en_d;
            bus_req_we_q      <= bus_req_we_d;
            bus_req_addr_q    <= bus_req_addr_d;
            bus_req_wdata_q   <= bus_req_wdata_d;
            bus_req_wstrb_q   <= bus_req_wstrb_d;
            fetch_resp_en_q   <= fetch_resp_en_d;
            fetch_resp_data_q <= fetch_resp_data_d;
            mem_resp_en_q     <= mem_resp_en_d;
            mem_resp_data_q   <= mem_resp_data_d;
        end
    end

    assign fetch_resp_en   = fetch_resp_en_q;
    assign fetch_resp_data = fetch_resp_data_q;
    assign mem_resp_en     = mem_resp_en_q;
    assign mem_resp_data   = mem_resp_data_q;
    assign bus_req_en      = bus_req_en_q;
    assign bus_req_we      = bus_req_we_q;
    assign bus_req_addr    = bus_req_addr_q;
    assign bus_req_wdata   = bus_req_wdata_q;
    assign bus_req_wstrb   = bus_req_wstrb_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized stimulus with a transaction-level reference model;
// expected bus requests and responses are queued and compared by an independent monitor.
module tb_mem_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SW   = 4;
    localparam int unsigned NCYC = 8192;

    localparam int BR_NONE  = 0;
    localparam int BR_FORCE = 1;
    localparam int BR_DUE   = 2;
    localparam int BR_AUTO  = 3;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          fetch_req_en = 1'b0;
    logic [AW-1:0] fetch_req_addr = '0;
    logic          fetch_resp_en;
    logic [DW-1:0] fetch_resp_data;
    logic          mem_req_en = 1'b0;
    logic          mem_req_we = 1'b0;
    logic [AW-1:0] mem_req_addr = '0;
    logic [DW-1:0] mem_req_wdata = '0;
    logic [SW-1:0] mem_req_wstrb = '0;
    logic          mem_resp_en;
    logic [DW-1:0] mem_resp_data;
    logic          bus_req_en;
    logic          bus_req_we;
    logic [AW-1:0] bus_req_addr;
    logic [DW-1:0] bus_req_wdata;
    logic [SW-1:0] bus_req_wstrb;
    logic          bus_resp_en = 1'b0;
    logic [DW-1:0] bus_resp_data = '0;
    logic          busy;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW)) dut (
        .clk(clk), .rstn(rstn),
        .fetch_req_en(fetch_req_en), .fetch_req_addr(fetch_req_addr),
        .fetch_resp_en(fetch_resp_en), .fetch_resp_data(fetch_resp_data),
        .mem_req_en(mem_req_en), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_en(mem_resp_en), .mem_resp_data(mem_resp_data),
        .bus_req_en(bus_req_en), .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
        .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
        .bus_resp_en(bus_resp_en), .bus_resp_data(bus_resp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } req_t;

    typedef struct {
        int            cyc;
        bit            mem;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } bus_exp_t;

    typedef struct {
        int            cyc;
        bit            mem;
        bit            chk_data;
        logic [DW-1:0] data;
    } resp_exp_t;

    bus_exp_t  bus_q[$];
    resp_exp_t resp_q[$];
    bit        busy_exp [NCYC];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: one outstanding request per requester (0 = fetch, 1 = mem).
    bit   pv [2];
    req_t pr [2];
    bit   inflight   = 1'b0;
    bit   owner      = 1'b0;
    bit   last_grant = 1'b0;
    int   resp_cycle = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    endtask

    task automatic set_busy(input int idx, input bit v);
        if (idx >= 0 && idx < int'(NCYC)) busy_exp[idx] = v;
    endtask

    task automatic step(input bit fe, input logic [AW-1:0] fa,
                        input bit me, input bit mwe, input logic [AW-1:0] ma,
                        input logic [DW-1:0] mwd, input logic [SW-1:0] mws,
                        input int br_mode, input logic [DW-1:0] bd);
        bit br;
        bit w;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        case (br_mode)
            BR_FORCE: br = 1'b1;
            BR_DUE:   br = inflight && (cyc >= resp_cycle);
            BR_AUTO:  br = inflight ? (cyc >= resp_cycle) : ($urandom_range(0, 9) == 0);
            default:  br = 1'b0;
        endcase
        fetch_req_en   = fe;
        fetch_req_addr = fa;
        mem_req_en     = me;
        mem_req_we     = mwe;
        mem_req_addr   = ma;
        mem_req_wdata  = mwd;
        mem_req_wstrb  = mws;
        bus_resp_en    = br;
        bus_resp_data  = bd;
        if (fe && !pv[0]) begin
            pv[0] = 1'b1;
            pr[0] = '{we: 1'b0, addr: fa, wdata: '0, wstrb: '0};
        end
        if (me && !pv[1]) begin
            pv[1] = 1'b1;
            pr[1] = '{we: mwe, addr: ma, wdata: mwd, wstrb: mws};
        end
        if (br && inflight) begin
            resp_q.push_back('{cyc: cyc + 1, mem: owner, chk_data: !pr[owner].we, data: bd});
            pv[owner] = 1'b0;
            inflight  = 1'b0;
            set_busy(cyc + 1, 1'b1);
        end else if (!inflight && (pv[0] || pv[1])) begin
            if (pv[0] && pv[1]) begin
`ifdef MEM_PORT_ARB_RR_EN
                w = ~last_grant;
`else
                w = 1'b1;
`endif
            end else begin
                w = pv[1];
            end
            bus_q.push_back('{cyc: cyc + 1, mem: w, we: pr[w].we, addr: pr[w].addr,
                              wdata: pr[w].wdata, wstrb: pr[w].wstrb});
            inflight   = 1'b1;
            owner      = w;
            last_grant = w;
            resp_cycle = cyc + 1 + int'($urandom_range(0, 4));
            set_busy(cyc + 1, 1'b1);
        end else begin
            set_busy(cyc + 1, inflight);
        end
    endtask

    task automatic idle(input int n, input int br_mode);
        for (int i = 0; i < n; i++) step(0, $urandom, 0, 0, $urandom, $urandom, 4'($urandom), br_mode, $urandom);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rstn = 1'b0;
            fetch_req_en = 1'b0;
            mem_req_en   = 1'b0;
            bus_resp_en  = 1'b0;
            bus_q.delete();
            resp_q.delete();
            pv[0] = 1'b0;
            pv[1] = 1'b0;
            inflight   = 1'b0;
            last_grant = 1'b0;
            set_busy(cyc, 1'b0);
            set_busy(cyc + 1, 1'b0);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a bus request or response.
    bus_exp_t  cur_bus;
    bit        have_cur = 1'b0;
    always @(negedge clk) begin
        bus_exp_t  be;
        resp_exp_t re;
        if (!rstn) begin
            have_cur = 1'b0;
            check("reset_ctrl", 64'({bus_req_en, bus_req_we, bus_req_wstrb, fetch_resp_en, mem_resp_en, busy}), 64'd0);
            check("reset_bus", {bus_req_addr, bus_req_wdata}, 64'd0);
            check("reset_resp", {fetch_resp_data, mem_resp_data}, 64'd0);
        end else begin
            if (bus_req_en) begin
                if (bus_q.size() == 0) begin
                    check("bus_req_unexpected", 64'(bus_req_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    be = bus_q.pop_front();
                    cur_bus  = be;
                    have_cur = 1'b1;
                    check("bus_req_cycle", 64'(cyc), 64'(be.cyc));
                    check("bus_req_addr", 64'(bus_req_addr), 64'(be.addr));
                    check("bus_req_we", 64'(bus_req_we), 64'(be.we));
                    if (be.mem && be.we) check("bus_req_wdata", 64'(bus_req_wdata), 64'(be.wdata));
                    if (!be.mem || be.we) check("bus_req_wstrb", 64'(bus_req_wstrb), 64'(be.wstrb));
                end
            end else begin
                if (bus_q.size() > 0 && bus_q[0].cyc <= cyc) begin
                    check("bus_req_missing", 64'(bus_req_en), 64'd1);
                    void'(bus_q.pop_front());
                end
                if (busy && have_cur)
                    check("bus_req_hold", {31'd0, bus_req_we, bus_req_addr}, {31'd0, cur_bus.we, cur_bus.addr});
            end
            if (fetch_resp_en || mem_resp_en) begin
                if (resp_q.size() == 0) begin
                    check("resp_unexpected", 64'({fetch_resp_en, mem_resp_en}), 64'd0);
                end else begin
                    re = resp_q.pop_front();
                    check("resp_cycle", 64'(cyc), 64'(re.cyc));
                    check("resp_owner", 64'({fetch_resp_en, mem_resp_en}), re.mem ? 64'd1 : 64'd2);
                    if (re.chk_data)
                        check("resp_data", 64'(re.mem ? mem_resp_data : fetch_resp_data), 64'(re.data));
                end
            end else if (resp_q.size() > 0 && resp_q[0].cyc <= cyc) begin
                check("resp_missing", 64'd0, 64'd1);
                void'(resp_q.pop_front());
            end
            if (cyc < int'(NCYC)) check("busy", 64'(busy), 64'(busy_exp[cyc]));
        end
    end

    initial begin
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        do_reset(3);

        // Single fetch: request at t, bus response at t+4
        step(1, 32'h0000_1000, 0, 0, 0, 0, 0, BR_NONE, 0);
        idle(3, BR_NONE);
        step(0, 0, 0, 0, 0, 0, 0, BR_FORCE, 32'hDEAD_BEEF);
        idle(3, BR_NONE);

        // Store
        step(0, 0, 1, 1, 32'h2004, 32'h1234_5678, 4'hF, BR_NONE, 0);
        idle(2, BR_NONE);
        step(0, 0, 0, 0, 0, 0, 0, BR_FORCE, 32'hAAAA_5555);
        idle(3, BR_NONE);

        // Simultaneous fetch and load
        step(1, 32'h100, 1, 0, 32'h200, 32'h0, 4'h3, BR_NONE, 0);
        idle(1, BR_NONE);
        step(0, 0, 0, 0, 0, 0, 0, BR_FORCE, 32'h0000_0200);
        idle(2, BR_NONE);
        step(0, 0, 0, 0, 0, 0, 0, BR_FORCE, 32'h0000_0100);
        idle(3, BR_NONE);

        // Both requesters re-request on every response
        step(1, 32'h500, 1, 0, 32'h600, 0, 0, BR_NONE, 0);
        for (int k = 0; k < 4; k++) begin
            idle(1, BR_NONE);
            step(0, 0, 0, 0, 0, 0, 0, BR_FORCE, $urandom);
            step(1, 32'h510 + 32'(k), 1, 0, 32'h610 + 32'(k), 0, 0, BR_NONE, 0);
        end
        for (int i = 0; i < 60 && (inflight || pv[0] || pv[1]); i++) idle(1, BR_DUE);
        idle(3, BR_NONE);

        // Duplicate fetch pulse while outstanding, then a stray response in IDLE
        step(1, 32'h100, 0, 0, 0, 0, 0, BR_NONE, 0);
        step(1, 32'h300, 0, 0, 0, 0, 0, BR_NONE, 0);
        step(0, 0, 0, 0, 0, 0, 0, BR_FORCE, 32'h1111_2222);
        idle(1, BR_NONE);
        step(0, 0, 0, 0, 0, 0, 0, BR_FORCE, 32'h3333_4444);
        idle(3, BR_NONE);

        // Reset while a fetch is outstanding
        step(1, 32'h400, 0, 0, 0, 0, 0, BR_NONE, 0);
        idle(2, BR_NONE);
        do_reset(2);
        step(0, 0, 0, 0, 0, 0, 0, BR_FORCE, 32'h5555_6666);
        idle(2, BR_NONE);
        step(1, 32'h404, 0, 0, 0, 0, 0, BR_NONE, 0);
        idle(1, BR_NONE);
        step(0, 0, 0, 0, 0, 0, 0, BR_FORCE, 32'h7777_8888);
        idle(3, BR_NONE);

        // Randomized traffic with random response latency and stray responses
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset(2);
            step($urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 2) == 0, 1'($urandom),
                 $urandom, $urandom, 4'($urandom), BR_AUTO, $urandom);
        end
        for (int i = 0; i < 100 && (inflight || pv[0] || pv[1]); i++) idle(1, BR_DUE);
        idle(4, BR_NONE);

        check("scoreboard_drained", 64'(bus_q.size() + resp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
